// File: rtl/mcdf_pkg.sv
// Shared types and constants for the MCDF packet receiver.
package mcdf_pkg;

  localparam int unsigned LEN_WIDE       = 6;
  localparam int unsigned CHID_WIDE      = 2;
  localparam int unsigned MCDF_DATA_WIDE = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_START,
    S_RECV
  } rcv_state_e;

  typedef struct packed {
    logic [CHID_WIDE-1:0]      chid;
    logic                      last;
    logic [MCDF_DATA_WIDE-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/mcdf_pkt_rcv_if.sv
// Formatter-side request/data bus and sink-side word stream of the packet receiver.
interface mcdf_fmt_if #(
  parameter int unsigned DATA_WIDE = 32
);
  logic                           fmt_req;
  logic [mcdf_pkg::CHID_WIDE-1:0] fmt_chid;
  logic [mcdf_pkg::LEN_WIDE-1:0]  fmt_length;
  logic                           fmt_start;
  logic                           fmt_end;
  logic [DATA_WIDE-1:0]           fmt_data;
  logic                           fmt_grant;

  modport master (
    output fmt_req, fmt_chid, fmt_length, fmt_start, fmt_end, fmt_data,
    input  fmt_grant
  );

  modport slave (
    input  fmt_req, fmt_chid, fmt_length, fmt_start, fmt_end, fmt_data,
    output fmt_grant
  );
endinterface

interface mcdf_pkt_if #(
  parameter int unsigned DATA_WIDE = 32
);
  logic                           pkt_valid;
  logic [DATA_WIDE-1:0]           pkt_data;
  logic [mcdf_pkg::CHID_WIDE-1:0] pkt_chid;
  logic                           pkt_last;
  logic                           pkt_ready;

  modport master (
    output pkt_valid, pkt_data, pkt_chid, pkt_last,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_chid, pkt_last,
    output pkt_ready
  );
endinterface

// File: rtl/mcdf_pkt_buf.sv
// Synchronous FIFO of {chid, last, data} entries with occupancy output.
module mcdf_pkt_buf
  import mcdf_pkg::*;
#(
  parameter int unsigned PTR_WIDE = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  buf_entry_t        push_entry_i,
  input  logic              pop_i,
  output buf_entry_t        head_o,
  output logic              valid_o,
  output logic [PTR_WIDE:0] occ_o
);

  localparam int unsigned DEPTH = 1 << PTR_WIDE;

  buf_entry_t          mem_q [DEPTH];
  logic [PTR_WIDE-1:0] wr_q, rd_q;
  logic [PTR_WIDE:0]   occ_q;
  logic                do_pop;

  // The receiver only grants packets that fit, so push never meets a full buffer.
  assign do_pop = pop_i && (occ_q != '0);

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Head is forced to zero when empty so the outputs read as reset values.
  assign valid_o = (occ_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign occ_o   = occ_q;

endmodule

// File: rtl/mcdf_pkt_rcv.sv
// MCDF packet receiver: grants formatter packets that fit the buffer, checks framing, re-emits words.
module mcdf_pkt_rcv
  import mcdf_pkg::*;
#(
  parameter int unsigned DATA_WIDE     = MCDF_DATA_WIDE,
  parameter int unsigned BUF_PTR_WIDE  = 6,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mcdf_fmt_if.slave         fmt,
  mcdf_pkt_if.master        pkt,
  output logic              err_len,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [7:0]        pkt_cnt0,
  output logic [7:0]        pkt_cnt1,
  output logic [7:0]        pkt_cnt2
);

  localparam int unsigned DEPTH   = 1 << BUF_PTR_WIDE;
  localparam int unsigned TO_WIDE = $clog2(START_TIMEOUT + 1);

  rcv_state_e           state_q, state_d;
  logic [CHID_WIDE-1:0] chid_q, chid_d;
  logic [LEN_WIDE-1:0]  len_q, len_d;
  logic [LEN_WIDE-1:0]  wcnt_q, wcnt_d;
  logic [TO_WIDE-1:0]   to_q, to_d;
  logic                 grant_q;
  logic                 err_len_q, err_to_q;
  logic [7:0]           cnt0_q, cnt1_q, cnt2_q;

  logic                 set_len, set_to, close, push, len_hit;
  buf_entry_t           push_entry, head;
  logic                 buf_valid;
  logic [BUF_PTR_WIDE:0] occ, free_words;

  // Free space comes from registered occupancy; pops can only add room.
  assign free_words = (BUF_PTR_WIDE + 1)'(DEPTH) - occ;

  always_comb begin
    state_d    = state_q;
    chid_d     = chid_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    to_d       = to_q;
    push       = 1'b0;
    set_len    = 1'b0;
    set_to     = 1'b0;
    close      = 1'b0;
    len_hit    = 1'b0;
    push_entry = '{chid: chid_q, last: 1'b0, data: fmt.fmt_data};

    case (state_q)
      S_IDLE: begin
        if (fmt.fmt_req) begin
          if (fmt.fmt_length == '0) begin
            set_len = 1'b1;
          end else if (free_words >= (BUF_PTR_WIDE + 1)'(fmt.fmt_length)) begin
            state_d = S_GRANT;
            chid_d  = fmt.fmt_chid;
            len_d   = fmt.fmt_length;
          end
        end
      end
      S_GRANT: begin
        state_d = S_WAIT_START;
        to_d    = '0;
      end
      S_WAIT_START: begin
        if (fmt.fmt_start) begin
          push    = 1'b1;
          wcnt_d  = LEN_WIDE'(1);
          state_d = S_RECV;
        end else if (to_q == TO_WIDE'(START_TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_RECV: begin
        push   = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if (fmt.fmt_start) set_len = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Close-out is shared by the first word and RECV words so length-1 packets need no extra state.
    if (push) begin
      len_hit = (wcnt_d == len_q);
      if (len_hit || fmt.fmt_end) begin
        close           = 1'b1;
        push_entry.last = 1'b1;
        state_d         = S_IDLE;
        if (len_hit != fmt.fmt_end) set_len = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      chid_q    <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      to_q      <= '0;
      grant_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
    end else begin
      state_q   <= state_d;
      chid_q    <= chid_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      to_q      <= to_d;
      grant_q   <= (state_d == S_GRANT);
      err_len_q <= err_clr ? 1'b0 : (err_len_q | set_len);
      err_to_q  <= err_clr ? 1'b0 : (err_to_q | set_to);
      if (close) begin
        case (chid_q)
          2'd0:    cnt0_q <= cnt0_q + 1'b1;
          2'd1:    cnt1_q <= cnt1_q + 1'b1;
          2'd2:    cnt2_q <= cnt2_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  mcdf_pkt_buf #(
    .PTR_WIDE (BUF_PTR_WIDE)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (buf_valid && pkt.pkt_ready),
    .head_o       (head),
    .valid_o      (buf_valid),
    .occ_o        (occ)
  );

  assign fmt.fmt_grant = grant_q;
  assign pkt.pkt_valid = buf_valid;
  assign pkt.pkt_data  = head.data;
  assign pkt.pkt_chid  = head.chid;
  assign pkt.pkt_last  = head.last;
  assign err_len       = err_len_q;
  assign err_timeout   = err_to_q;
  assign pkt_cnt0      = cnt0_q;
  assign pkt_cnt1      = cnt1_q;
  assign pkt_cnt2      = cnt2_q;

endmodule

// File: tb/tb_mcdf_pkt_rcv.sv
// Scoreboard bench for mcdf_pkt_rcv: directed scenarios plus randomized packets against a queue model.
`timescale 1ns/1ps
module tb_mcdf_pkt_rcv;
  import mcdf_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 6;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic       err_len, err_timeout;
  logic [7:0] pkt_cnt0, pkt_cnt1, pkt_cnt2;

  mcdf_fmt_if #(.DATA_WIDE(DW)) fmt_bus ();
  mcdf_pkt_if #(.DATA_WIDE(DW)) pkt_bus ();

  mcdf_pkt_rcv #(
    .DATA_WIDE     (DW),
    .BUF_PTR_WIDE  (PW),
    .START_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fmt         (fmt_bus),
    .pkt         (pkt_bus),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .pkt_cnt0    (pkt_cnt0),
    .pkt_cnt1    (pkt_cnt1),
    .pkt_cnt2    (pkt_cnt2)
  );

  always #5 clk = ~clk;

  int unsigned  checks = 0;
  int unsigned  fails  = 0;
  logic [34:0]  exp_q[$];
  int unsigned  exp_cnt[4];
  bit           exp_err_len = 1'b0;
  bit           exp_err_to  = 1'b0;
  int unsigned  grant_cnt   = 0;
  bit           prev_grant  = 1'b0;
  bit           rand_ready  = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples after the bench has driven its inputs for the cycle.
  always begin
    logic [34:0] e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (fmt_bus.fmt_grant) begin
        chk("grant_pulse_width", 64'(prev_grant), 0);
        grant_cnt++;
      end
      prev_grant = fmt_bus.fmt_grant;
      if (pkt_bus.pkt_valid && pkt_bus.pkt_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("word", {pkt_bus.pkt_chid, pkt_bus.pkt_last, pkt_bus.pkt_data}, e);
        end
      end
    end else begin
      prev_grant = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (rand_ready) pkt_bus.pkt_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fmt_quiet();
    fmt_bus.fmt_req    = 1'b0;
    fmt_bus.fmt_start  = 1'b0;
    fmt_bus.fmt_end    = 1'b0;
    fmt_bus.fmt_data   = '0;
  endtask

  task automatic request(input logic [1:0] ch, input int len, input int budget,
                         output bit ok, output int lat);
    fmt_bus.fmt_req    = 1'b1;
    fmt_bus.fmt_chid   = ch;
    fmt_bus.fmt_length = 6'(len);
    ok  = 1'b0;
    lat = 0;
    while (!ok && lat < budget) begin
      tick();
      lat++;
      if (fmt_bus.fmt_grant) ok = 1'b1;
    end
    fmt_bus.fmt_req = 1'b0;
    if (!ok) chk("grant_wait_expired", 64'(lat), 0);
  endtask

  // Formatter data phase; the reference model records what the receiver must emit.
  task automatic send_data(input logic [1:0] ch, input int len, input int endpos,
                           input int delay, input int extra);
    int nw;
    logic [31:0] d;
    nw = (endpos != 0 && endpos < len) ? endpos : len;
    repeat (1 + delay) tick();
    for (int i = 1; i <= nw + extra; i++) begin
      d = $urandom;
      fmt_bus.fmt_start = (i == 1);
      fmt_bus.fmt_end   = (i == endpos);
      fmt_bus.fmt_data  = d;
      if (i <= nw) exp_q.push_back({ch, (i == nw), d});
      tick();
    end
    fmt_quiet();
    if (ch != 2'd3) exp_cnt[ch] = (exp_cnt[ch] + 1) % 256;
    if (endpos != len) exp_err_len = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    pkt_bus.pkt_ready = 1'b1;
    while ((exp_q.size() != 0 || pkt_bus.pkt_valid) && n < 500) begin
      tick();
      n++;
    end
    tick();
    chk("drain_leftover", 64'(exp_q.size()), 0);
    chk("drain_valid", 64'(pkt_bus.pkt_valid), 0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err_len = 1'b0;
    exp_err_to  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_err_len"}, 64'(err_len), 64'(exp_err_len));
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(exp_err_to));
    chk({tag, "_cnt0"}, 64'(pkt_cnt0), 64'(exp_cnt[0]));
    chk({tag, "_cnt1"}, 64'(pkt_cnt1), 64'(exp_cnt[1]));
    chk({tag, "_cnt2"}, 64'(pkt_cnt2), 64'(exp_cnt[2]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 64'(fmt_bus.fmt_grant), 0);
    chk({tag, "_valid"}, 64'(pkt_bus.pkt_valid), 0);
    chk({tag, "_data"}, 64'(pkt_bus.pkt_data), 0);
    chk({tag, "_chid"}, 64'(pkt_bus.pkt_chid), 0);
    chk({tag, "_last"}, 64'(pkt_bus.pkt_last), 0);
    check_status(tag);
  endtask

  initial begin
    bit ok;
    int lat;
    int unsigned g0;
    int len, endpos, r;
    logic [1:0] ch;

    fmt_quiet();
    fmt_bus.fmt_chid   = '0;
    fmt_bus.fmt_length = '0;
    pkt_bus.pkt_ready  = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

    #2;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single packet, ch1 length 4
    pkt_bus.pkt_ready = 1'b1;
    request(2'd1, 4, 50, ok, lat);
    chk("single_grant_latency", 64'(lat), 1);
    send_data(2'd1, 4, 4, 0, 0);
    drain();
    check_status("single");

    // Zero length request: refused and flagged
    g0 = grant_cnt;
    fmt_bus.fmt_req = 1'b1;
    fmt_bus.fmt_length = '0;
    repeat (4) tick();
    fmt_bus.fmt_req = 1'b0;
    exp_err_len = 1'b1;
    tick();
    chk("zero_len_no_grant", 64'(grant_cnt - g0), 0);
    check_status("zero_len");
    clear_errors();
    chk("zero_len_cleared", 64'(err_len), 0);

    // Backpressure: two full-size packets fill the 64-entry buffer
    pkt_bus.pkt_ready = 1'b0;
    g0 = grant_cnt;
    request(2'd0, 32, 50, ok, lat);
    send_data(2'd0, 32, 32, 0, 0);
    request(2'd0, 32, 50, ok, lat);
    send_data(2'd0, 32, 32, 0, 0);
    fmt_bus.fmt_req = 1'b1;
    fmt_bus.fmt_chid = 2'd0;
    fmt_bus.fmt_length = 6'd32;
    repeat (40) tick();
    chk("bp_two_grants_only", 64'(grant_cnt - g0), 2);
    chk("bp_full_valid", 64'(pkt_bus.pkt_valid), 1);
    pkt_bus.pkt_ready = 1'b1;
    request(2'd0, 32, 200, ok, lat);
    chk("bp_third_grant", 64'(ok), 1);
    chk("bp_third_after_pops", 64'(lat >= 32), 1);
    send_data(2'd0, 32, 32, 2, 0);
    drain();
    check_status("bp");

    // Early end: length 8 with end on word 5
    request(2'd2, 8, 50, ok, lat);
    send_data(2'd2, 8, 5, 1, 0);
    drain();
    check_status("early_end");
    clear_errors();
    chk("early_end_cleared", 64'(err_len), 0);

    // Missing end: closes on length, trailing words ignored
    request(2'd0, 4, 50, ok, lat);
    send_data(2'd0, 4, 0, 0, 3);
    drain();
    check_status("late_end");
    clear_errors();
    chk("late_end_cleared", 64'(err_len), 0);

    // Start timeout
    request(2'd1, 4, 50, ok, lat);
    repeat (10) tick();
    chk("timeout_not_yet", 64'(err_timeout), 0);
    repeat (15) tick();
    exp_err_to = 1'b1;
    check_status("timeout");
    chk("timeout_nothing_buffered", 64'(pkt_bus.pkt_valid), 0);
    request(2'd1, 3, 50, ok, lat);
    chk("timeout_next_grant", 64'(lat), 1);
    send_data(2'd1, 3, 3, 0, 0);
    drain();
    check_status("after_timeout");
    clear_errors();
    chk("timeout_cleared", 64'(err_timeout), 0);

    // Reset on word 3 of 8
    pkt_bus.pkt_ready = 1'b0;
    request(2'd2, 8, 50, ok, lat);
    tick();
    for (int i = 1; i <= 3; i++) begin
      fmt_bus.fmt_start = (i == 1);
      fmt_bus.fmt_data  = $urandom;
      if (i < 3) tick();
    end
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    exp_err_len = 1'b0;
    exp_err_to  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      fmt_bus.fmt_start = 1'b0;
      fmt_bus.fmt_end   = (i == 8);
      fmt_bus.fmt_data  = $urandom;
      tick();
      chk("midrst_trailing_ignored", 64'(pkt_bus.pkt_valid), 0);
    end
    fmt_quiet();
    pkt_bus.pkt_ready = 1'b1;
    request(2'd2, 2, 50, ok, lat);
    chk("midrst_next_grant", 64'(lat), 1);
    send_data(2'd2, 2, 2, 0, 0);
    drain();
    check_status("midrst_after");

    // Randomized packets with random sink backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      ch  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 32);
      r   = $urandom_range(0, 9);
      if (r < 7)       endpos = len;
      else if (r == 7) endpos = $urandom_range(1, len);
      else             endpos = 0;
      request(ch, len, 2000, ok, lat);
      if (ok) send_data(ch, len, endpos, $urandom_range(0, 4), $urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    tick();
    drain();
    check_status("random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
